// File: rtl/divide_tokens_multi.sv
// Multi-channel runtime-programmable token divider: each channel emits one
// output token per div_reg input tokens, on the first or last token of a group.
module divide_tokens_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CNT_W-1:0]        cfg_div,
  input  logic                    cfg_mode,
  input  logic [N_CH-1:0]         clr,
  input  logic [N_CH-1:0]         a,
  output logic [N_CH-1:0]         b,
  output logic [N_CH*CNT_W-1:0]   cnt,
  output logic [N_CH-1:0]         busy
);

  logic [CNT_W-1:0] div_reg;
  logic             mode_reg;
  logic [CNT_W-1:0] last_val;
  logic             chan_en;

  // Reset default of divide-by-two in LAST mode gives halve-tokens behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg  <= CNT_W'(2);
      mode_reg <= 1'b0;
    end else if (cfg_we) begin
      div_reg  <= cfg_div;
      mode_reg <= cfg_mode;
    end
  end

  // For div_reg=0 last_val wraps to all ones, but chan_en masks every use.
  assign last_val = div_reg - CNT_W'(1);
  assign chan_en  = (div_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             at_last;
      logic             take;

      assign at_last = (cnt_reg == last_val);
      assign take    = a[gi] & ~cfg_we & ~clr[gi] & chan_en;

      always_comb begin
        cnt_next = cnt_reg;
        if (cfg_we || clr[gi] || !chan_en) begin
          cnt_next = '0;
        end else if (a[gi]) begin
          cnt_next = at_last ? '0 : cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      // With div_reg=1 both mode conditions reduce to cnt_reg==0, so b follows a.
      assign b[gi]                     = take & (mode_reg ? (cnt_reg == '0) : at_last);
      assign cnt[gi*CNT_W +: CNT_W]    = cnt_reg;
      assign busy[gi]                  = (cnt_reg != '0);
    end
  endgenerate

endmodule

// File: tb/tb_divide_tokens_multi.sv
// Self-checking bench for divide_tokens_multi: per-cycle scoreboard of b plus
// scenario checks of token totals, counters and reset behaviour.
module tb_divide_tokens_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst;
  logic                  cfg_we;
  logic [CNT_W-1:0]      cfg_div;
  logic                  cfg_mode;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       b;
  logic [N_CH*CNT_W-1:0] cnt;
  logic [N_CH-1:0]       busy;

  divide_tokens_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .clr(clr), .a(a), .b(b), .cnt(cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int cyc;
  logic [N_CH-1:0]       exp_q[$];
  logic [N_CH-1:0]       obs_b;
  logic [N_CH-1:0]       exp_b;
  logic [N_CH*CNT_W-1:0] obs_cnt;

  // Reference state of the divider
  int m_div;
  int m_mode;
  int m_cnt[N_CH];

  function automatic logic [N_CH-1:0] model_b(input logic we, input logic [N_CH-1:0] c,
                                              input logic [N_CH-1:0] av);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!we && !c[i] && m_div != 0 && av[i])
        r[i] = (m_mode != 0) ? (m_cnt[i] == 0) : (m_cnt[i] == m_div - 1);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_div  = 2;
    m_mode = 0;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
  endtask

  task automatic model_clock(input logic we, input logic [CNT_W-1:0] dv, input logic md,
                             input logic [N_CH-1:0] c, input logic [N_CH-1:0] av);
    if (we) begin
      m_div  = int'(dv);
      m_mode = int'(md);
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (c[i]) m_cnt[i] = 0;
        else if (m_div != 0 && av[i]) m_cnt[i] = (m_cnt[i] == m_div - 1) ? 0 : m_cnt[i] + 1;
      end
    end
  endtask

  // One clock cycle: drive, push expectation, sample at negedge, advance.
  task automatic step(input logic we, input logic [CNT_W-1:0] dv, input logic md,
                      input logic [N_CH-1:0] c, input logic [N_CH-1:0] av);
    cfg_we = we; cfg_div = dv; cfg_mode = md; clr = c; a = av;
    exp_q.push_back(model_b(we, c, av));
    @(negedge clk);
    obs_b   = b;
    obs_cnt = cnt;
    $display("cyc %0d we=%b div=%0d mode=%b clr=%b a=%b b=%b cnt=%h", cyc, we, dv, md, c, av, obs_b, obs_cnt);
    model_clock(we, dv, md, c, av);
    @(posedge clk);
    #1;
    cyc++;
    cfg_we = 1'b0; clr = '0; a = '0;
  endtask

  task automatic test_reset();
    a = '1;
    #1;
    n_cmp++;
    if (cnt !== '0 || busy !== '0 || b !== '0) begin
      n_bad++;
      $display("FAIL reset_state: cnt=%h busy=%b b=%b required cnt=0 busy=0 b=0", cnt, busy, b);
    end
    a = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_default_halve();
    int ta[N_CH];
    int tb[N_CH];
    logic [N_CH-1:0] av;
    for (int i = 0; i < N_CH; i++) begin ta[i] = 0; tb[i] = 0; end
    for (int k = 0; k < 300; k++) begin
      av = (k < 100) ? N_CH'($urandom_range(0, 15)) : '0;
      step(1'b0, '0, 1'b0, '0, av);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== exp_b) begin
        n_bad++;
        $display("FAIL default_b cyc %0d: got %b required %b", cyc, obs_b, exp_b);
      end
      for (int i = 0; i < N_CH; i++) begin
        ta[i] += int'(av[i]);
        tb[i] += int'(obs_b[i]);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      n_cmp++;
      if (tb[i] != ta[i] / 2) begin
        n_bad++;
        $display("FAIL default_total ch%0d: got %0d required %0d", i, tb[i], ta[i] / 2);
      end
    end
  endtask

  task automatic test_div3_last();
    step(1'b1, 8'd3, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, '0, 1'b0, '0, 4'b0010);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== exp_b || obs_b[1] !== ((k == 3) || (k == 6))) begin
        n_bad++;
        $display("FAIL div3_last token %0d: got %b required %b", k, obs_b, exp_b);
      end
    end
    n_cmp++;
    if (cnt[1*CNT_W +: CNT_W] !== 8'd1 || busy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL div3_last_cnt: got cnt1=%0d busy1=%b required 1 1", cnt[1*CNT_W +: CNT_W], busy[1]);
    end
  endtask

  task automatic test_div3_first();
    int pulses;
    pulses = 0;
    step(1'b1, 8'd3, 1'b1, '0, '0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, '0, 1'b0, '0, 4'b0100);
      exp_b = exp_q.pop_front();
      pulses += int'(obs_b[2]);
      n_cmp++;
      if (obs_b !== exp_b || obs_b[2] !== ((k == 1) || (k == 4) || (k == 7))) begin
        n_bad++;
        $display("FAIL div3_first token %0d: got %b required %b", k, obs_b, exp_b);
      end
    end
    n_cmp++;
    if (pulses != 3 || cnt[2*CNT_W +: CNT_W] !== 8'd1) begin
      n_bad++;
      $display("FAIL div3_first_total: got pulses=%0d cnt2=%0d required 3 1", pulses, cnt[2*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_div1_div0();
    logic [N_CH-1:0] av;
    step(1'b1, 8'd1, 1'b0, '0, '1);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (obs_b !== '0) begin
      n_bad++;
      $display("FAIL cfg_cycle_b: got %b required 0000", obs_b);
    end
    for (int k = 0; k < 12; k++) begin
      av = N_CH'($urandom_range(0, 15));
      step(1'b0, '0, 1'b0, '0, av);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== av || obs_b !== exp_b || obs_cnt !== '0) begin
        n_bad++;
        $display("FAIL div1_pass: got b=%b cnt=%h required b=%b cnt=0", obs_b, obs_cnt, av);
      end
    end
    step(1'b1, 8'd0, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 1'b0, '0, '1);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== '0 || obs_b !== exp_b || obs_cnt !== '0) begin
        n_bad++;
        $display("FAIL div0_block: got b=%b cnt=%h required b=0000 cnt=0", obs_b, obs_cnt);
      end
    end
  endtask

  task automatic test_clr();
    int pulses;
    pulses = 0;
    step(1'b1, 8'd4, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    step(1'b0, '0, 1'b0, '0, 4'b1001);
    void'(exp_q.pop_front());
    step(1'b0, '0, 1'b0, '0, 4'b0001);
    void'(exp_q.pop_front());
    step(1'b0, '0, 1'b0, 4'b0001, 4'b0001);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (obs_b !== '0 || exp_b !== '0) begin
      n_bad++;
      $display("FAIL clr_b: got %b required 0000", obs_b);
    end
    n_cmp++;
    if (cnt[0 +: CNT_W] !== 8'd0 || cnt[3*CNT_W +: CNT_W] !== 8'd1) begin
      n_bad++;
      $display("FAIL clr_cnt: got cnt0=%0d cnt3=%0d required 0 1", cnt[0 +: CNT_W], cnt[3*CNT_W +: CNT_W]);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, 1'b0, '0, 4'b0001);
      exp_b = exp_q.pop_front();
      pulses += int'(obs_b[0]);
      n_cmp++;
      if (obs_b !== exp_b) begin
        n_bad++;
        $display("FAIL clr_after token %0d: got %b required %b", k, obs_b, exp_b);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL clr_total: got %0d required 1", pulses);
    end
  endtask

  task automatic test_wrap_and_reset();
    int pulses;
    int first_at;
    int second_at;
    pulses = 0; first_at = -1; second_at = -1;
    step(1'b1, 8'd255, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 600; k++) begin
      step(1'b0, '0, 1'b0, '0, 4'b1000);
      exp_b = exp_q.pop_front();
      if (obs_b[3]) begin
        pulses++;
        if (first_at < 0) first_at = k; else second_at = k;
      end
      if (obs_b !== exp_b) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wrap_b token %0d: got %b required %b", k, obs_b, exp_b);
      end
    end
    n_cmp++;
    if (pulses != 2 || first_at != 255 || second_at != 510) begin
      n_bad++;
      $display("FAIL wrap_pulses: got %0d at %0d,%0d required 2 at 255,510", pulses, first_at, second_at);
    end
    n_cmp++;
    if (cnt[3*CNT_W +: CNT_W] !== 8'd90) begin
      n_bad++;
      $display("FAIL wrap_cnt3: got %0d required 90", cnt[3*CNT_W +: CNT_W]);
    end
    // Asynchronous reset in the middle of a cycle, away from any edge
    a = 4'b1000;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cnt !== '0 || b !== '0 || busy !== '0) begin
      n_bad++;
      $display("FAIL midreset: got cnt=%h b=%b busy=%b required all 0", cnt, b, busy);
    end
    model_reset();
    exp_q.delete();
    a = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, 1'b0, '0, 4'b1000);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== exp_b || obs_b[3] !== ((k % 2) == 0)) begin
        n_bad++;
        $display("FAIL post_reset_halve token %0d: got %b required %b", k, obs_b, exp_b);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b0; cfg_we = 1'b0; cfg_div = '0; cfg_mode = 1'b0; clr = '0; a = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_default_halve();
    test_div3_last();
    test_div3_first();
    test_div1_div0();
    test_clr();
    test_wrap_and_reset();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: got no completion required completion within 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
